// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU: multi-cycle (optionally jittered) word reads
// and byte-masked stores into a word-organized array.
module lsu_mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2,
  parameter bit          RAND_EN     = 1'b0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        ready,
  output logic [31:0] data,
  output logic        err,
  input  logic        wen,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [7:0]  wmask,
  output logic [1:0]  dbg_state
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = 9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Handshake: req is a level held by the LSU; ready is a one-cycle registered
  // pulse during RESP, and data/err are meaningful while ready=1 and hold afterwards.

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ok_q, ok_d;
  logic          ready_q;
  logic [31:0]   data_q;
  logic          err_q;

  logic [31:0]   r_off, w_off;
  logic          r_ok, w_ok;
  logic [IW-1:0] r_idx, w_idx;
  logic [7:0]    lfsr_step;
  logic [1:0]    extra;
  logic          load;
  logic [IW-1:0] rd_idx;
  logic          rd_ok;
  logic          unused_bits;

  assign r_off = addr - BASE_ADDR;
  assign w_off = waddr - BASE_ADDR;
  assign r_ok  = (addr >= BASE_ADDR) && ((r_off >> 2) < 32'(DEPTH_WORDS));
  assign w_ok  = (waddr >= BASE_ADDR) && ((w_off >> 2) < 32'(DEPTH_WORDS));
  assign r_idx = r_off[IW+1:2];
  assign w_idx = w_off[IW+1:2];
  assign unused_bits = ^{wmask[7:4], r_off[1:0], w_off[1:0]};

  // Galois right-shift form of x^8+x^6+x^5+x^4+1.
  assign lfsr_step = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  assign extra     = RAND_EN ? lfsr_q[1:0] : 2'b00;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    load    = 1'b0;
    rd_idx  = idx_q;
    rd_ok   = ok_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d  = r_idx;
          ok_d   = r_ok;
          lfsr_d = lfsr_step;
          cnt_d  = CW'(LATENCY - 1) + CW'(extra);
          if (cnt_d == '0) begin
            state_d = S_RESP;
            load    = 1'b1;
            rd_idx  = r_idx;
            rd_ok   = r_ok;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_RESP;
          load    = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      ready_q <= (state_d == S_RESP);
      // Nonblocking store below lands after this read: read-before-write.
      if (load) begin
        data_q <= rd_ok ? mem[rd_idx] : '0;
        err_q  <= ~rd_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wen && w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign ready     = ready_q;
  assign data      = data_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
